// File: rtl/slot_score_keeper.sv
// ---------------------------------------------------------------------------
// slot_score_keeper
//   Credit and score stage that sits behind the reel controller. A spin is
//   accepted only when enough credit is available; the bet is then debited
//   one BCD count per cycle. When the reels settle, the three digits are
//   scored and the payout is counted back into a 3-digit BCD credit total,
//   saturating at 999.
//
// Ports
//   i_clock       game clock
//   i_reset       synchronous active-high reset
//   i_spin_start  1-cycle pulse, player asks the reels to start
//   i_spin_done   1-cycle pulse, all three reels are now paused
//   i_reel0..2    reel digits, captured on an accepted i_spin_done
//   o_spin_ok     start request accepted this cycle (combinational pulse)
//   o_busy        high in every state except IDLE
//   o_win         last scored spin paid something; cleared on the next start
//   o_game_over   idle with credit below the bet
//   o_credit0..2  BCD credit digits: ones, tens, hundreds
// ---------------------------------------------------------------------------
module slot_score_keeper #(
  parameter int START_CREDIT = 10,
  parameter int BET          = 1,
  parameter int PAY_PAIR     = 2,
  parameter int PAY_TRIPLE   = 10,
  parameter int PAY_SEVEN    = 50
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_spin_start,
  input  logic       i_spin_done,
  input  logic [3:0] i_reel0,
  input  logic [3:0] i_reel1,
  input  logic [3:0] i_reel2,
  output logic       o_spin_ok,
  output logic       o_busy,
  output logic       o_win,
  output logic       o_game_over,
  output logic [3:0] o_credit0,
  output logic [3:0] o_credit1,
  output logic [3:0] o_credit2
);

  typedef enum logic [2:0] {IDLE, DEBIT, SPIN, EVAL, PAYOUT} state_t;

  localparam logic [11:0] START_BCD = {4'((START_CREDIT / 100) % 10),
                                       4'((START_CREDIT / 10) % 10),
                                       4'(START_CREDIT % 10)};

  state_t      state_q, state_d;
  logic [11:0] credit_q, credit_d;
  logic [6:0]  pay_q, pay_d;
  logic [3:0]  bet_cnt_q, bet_cnt_d;
  logic        win_q, win_d;
  logic [3:0]  reel0_q, reel0_d, reel1_q, reel1_d, reel2_q, reel2_d;
  logic [6:0]  score;
  logic        credit_short;

  // BCD +1 with the carry rippling through all three digits in one cycle.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    {d2, d1, d0} = v;
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {d2, d1, d0};
  endfunction

  // BCD -1; the DEBIT guard means 000 is never decremented.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    {d2, d1, d0} = v;
    if (d0 == 4'd0) begin
      d0 = 4'd9;
      if (d1 == 4'd0) begin
        d1 = 4'd9;
        d2 = (d2 == 4'd0) ? 4'd9 : d2 - 4'd1;
      end else begin
        d1 = d1 - 4'd1;
      end
    end else begin
      d0 = d0 - 4'd1;
    end
    return {d2, d1, d0};
  endfunction

  // Since BET is a single digit, credit < BET only when both upper digits are 0.
  assign credit_short = (credit_q[11:4] == 8'h00) && (credit_q[3:0] < 4'(BET));

  // Scoring of the latched reels; any non-decimal digit voids the whole spin.
  always_comb begin
    logic valid, e01, e12, e02;
    score = 7'd0;
    valid = (reel0_q <= 4'd9) && (reel1_q <= 4'd9) && (reel2_q <= 4'd9);
    e01   = (reel0_q == reel1_q);
    e12   = (reel1_q == reel2_q);
    e02   = (reel0_q == reel2_q);
    if (valid) begin
      if (e01 && e12) begin
        score = (reel0_q == 4'd7) ? 7'(PAY_SEVEN) : 7'(PAY_TRIPLE);
      end else if (e01 || e12 || e02) begin
        score = 7'(PAY_PAIR);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    pay_d     = pay_q;
    bet_cnt_d = bet_cnt_q;
    win_d     = win_q;
    reel0_d   = reel0_q;
    reel1_d   = reel1_q;
    reel2_d   = reel2_q;
    o_spin_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_spin_start && !credit_short) begin
          o_spin_ok = 1'b1;
          win_d     = 1'b0;
          bet_cnt_d = 4'(BET - 1);
          state_d   = DEBIT;
        end
      end
      DEBIT: begin
        credit_d = bcd_dec(credit_q);
        if (bet_cnt_q == 4'd0) state_d = SPIN;
        else                   bet_cnt_d = bet_cnt_q - 4'd1;
      end
      SPIN: begin
        if (i_spin_done) begin
          reel0_d = i_reel0;
          reel1_d = i_reel1;
          reel2_d = i_reel2;
          state_d = EVAL;
        end
      end
      EVAL: begin
        pay_d   = score;
        win_d   = (score != 7'd0);
        state_d = (score != 7'd0) ? PAYOUT : IDLE;
      end
      PAYOUT: begin
        if (credit_q == 12'h999) begin
          // Saturated: whatever payout is left is forfeited.
          pay_d   = 7'd0;
          state_d = IDLE;
        end else begin
          credit_d = bcd_inc(credit_q);
          pay_d    = pay_q - 7'd1;
          if (pay_q == 7'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      credit_q  <= START_BCD;
      pay_q     <= 7'd0;
      bet_cnt_q <= 4'd0;
      win_q     <= 1'b0;
      reel0_q   <= 4'd0;
      reel1_q   <= 4'd0;
      reel2_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      pay_q     <= pay_d;
      bet_cnt_q <= bet_cnt_d;
      win_q     <= win_d;
      reel0_q   <= reel0_d;
      reel1_q   <= reel1_d;
      reel2_q   <= reel2_d;
    end
  end

  assign o_busy      = (state_q != IDLE);
  assign o_win       = win_q;
  assign o_game_over = (state_q == IDLE) && credit_short;
  assign o_credit0   = credit_q[3:0];
  assign o_credit1   = credit_q[7:4];
  assign o_credit2   = credit_q[11:8];

endmodule
